// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: grant encoding, memory request bundle and
// the fixed access size used by the debug/loader port.
package dmem_arb_pkg;

    localparam int unsigned PKG_DATA_W = 32;
    localparam int unsigned PKG_ADDR_W = 9;

    // Debug accesses are always full words.
    localparam logic [2:0] DBG_F3 = 3'b010;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CORE = 2'd1,
        GNT_DBG  = 2'd2
    } grant_e;

    typedef struct packed {
        logic                  rd;
        logic                  wr;
        logic [PKG_ADDR_W-1:0] addr;
        logic [PKG_DATA_W-1:0] wdata;
        logic [2:0]            f3;
    } mem_req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle around the data-memory arbiter: core MEM-stage port, debug/loader port and the
// datamemory port. The arbiter uses the slave view; the surrounding system uses master.
interface dmem_arbiter_if #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DM_ADDRESS = 9
);

    logic                  core_rd;
    logic                  core_wr;
    logic [DM_ADDRESS-1:0] core_addr;
    logic [DATA_W-1:0]     core_wdata;
    logic [2:0]            core_f3;
    logic [DATA_W-1:0]     core_rdata;
    logic                  core_stall;

    logic                  dbg_valid;
    logic                  dbg_we;
    logic [DM_ADDRESS-1:0] dbg_addr;
    logic [DATA_W-1:0]     dbg_wdata;
    logic                  dbg_ready;
    logic                  dbg_rvalid;
    logic [DATA_W-1:0]     dbg_rdata;

    logic                  mem_rd;
    logic                  mem_wr;
    logic [DM_ADDRESS-1:0] mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [2:0]            mem_f3;
    logic [DATA_W-1:0]     mem_rdata;

    modport slave (
        input  core_rd, core_wr, core_addr, core_wdata, core_f3,
        output core_rdata, core_stall,
        input  dbg_valid, dbg_we, dbg_addr, dbg_wdata,
        output dbg_ready, dbg_rvalid, dbg_rdata,
        output mem_rd, mem_wr, mem_addr, mem_wdata, mem_f3,
        input  mem_rdata
    );

    modport master (
        output core_rd, core_wr, core_addr, core_wdata, core_f3,
        input  core_rdata, core_stall,
        output dbg_valid, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_ready, dbg_rvalid, dbg_rdata,
        input  mem_rd, mem_wr, mem_addr, mem_wdata, mem_f3,
        output mem_rdata
    );

endinterface

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive cycles a debug request has been refused.
// sat flags that the next debug request must be forced through.
module arb_starve_counter #(
    parameter int unsigned MAX_WAIT = 4,
    localparam int unsigned CntW    = $clog2(MAX_WAIT + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            inc,
    input  logic            clr,
    output logic [CntW-1:0] cnt,
    output logic            sat
);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    assign sat = (cnt_q == CntW'(MAX_WAIT));
    assign cnt = cnt_q;

    // Clear wins over increment so a handshake always restarts the window.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !sat) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single data-memory port between the core MEM stage and a debug/loader port.
// Optional grant/stall statistics counters are built when DMEM_ARB_STATS_EN is defined.
import dmem_arb_pkg::*;

module dmem_arbiter #(
    parameter int unsigned DATA_W     = PKG_DATA_W,
    parameter int unsigned DM_ADDRESS = PKG_ADDR_W,
    parameter int unsigned MAX_WAIT   = 4
) (
    input  logic        clk,
    input  logic        reset,
`ifdef DMEM_ARB_STATS_EN
    output logic [31:0] stat_core_gnt,
    output logic [31:0] stat_dbg_gnt,
    output logic [31:0] stat_stall,
`endif
    dmem_arbiter_if.slave bus
);

    localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

    grant_e          grant;
    logic            core_req;
    logic            dbg_ready;
    logic            core_stall;
    logic            wait_inc;
    logic            wait_clr;
    logic            wait_sat;
    logic [CntW-1:0] wait_cnt;
    mem_req_t        req;
    logic            dbg_rd_acc;
    logic            rvalid_q;
    logic [DATA_W-1:0] rdata_q;

    assign core_req = bus.core_rd | bus.core_wr;

    // Grant decision: core has priority unless dbg has been refused MAX_WAIT cycles in a row.
    always_comb begin
        grant      = GNT_NONE;
        dbg_ready  = 1'b0;
        core_stall = 1'b0;
        if (!reset) begin
            if (bus.dbg_valid && (!core_req || wait_sat)) begin
                grant      = GNT_DBG;
                dbg_ready  = 1'b1;
                core_stall = core_req;
            end else if (core_req) begin
                grant = GNT_CORE;
            end
        end
    end

    assign wait_inc = bus.dbg_valid & ~dbg_ready;
    assign wait_clr = ~bus.dbg_valid | dbg_ready;

    arb_starve_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .inc   (wait_inc),
        .clr   (wait_clr),
        .cnt   (wait_cnt),
        .sat   (wait_sat)
    );

    always_comb begin
        req = '0;
        unique case (grant)
            GNT_CORE: begin
                req = '{rd: bus.core_rd, wr: bus.core_wr, addr: bus.core_addr,
                        wdata: bus.core_wdata, f3: bus.core_f3};
            end
            GNT_DBG: begin
                req = '{rd: ~bus.dbg_we, wr: bus.dbg_we, addr: bus.dbg_addr,
                        wdata: bus.dbg_wdata, f3: DBG_F3};
            end
            default: begin
                req = '0;
            end
        endcase
    end

    assign bus.mem_rd     = req.rd;
    assign bus.mem_wr     = req.wr;
    assign bus.mem_addr   = req.addr;
    assign bus.mem_wdata  = req.wdata;
    assign bus.mem_f3     = req.f3;
    assign bus.core_rdata = (grant == GNT_CORE) ? bus.mem_rdata : '0;
    assign bus.core_stall = core_stall;
    assign bus.dbg_ready  = dbg_ready;

    assign dbg_rd_acc = (grant == GNT_DBG) && !bus.dbg_we;

    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= dbg_rd_acc;
            if (dbg_rd_acc) begin
                rdata_q <= bus.mem_rdata;
            end
        end
    end

    // Masked by reset so a response already registered when reset arrives is dropped.
    assign bus.dbg_rvalid = rvalid_q & ~reset;
    assign bus.dbg_rdata  = reset ? '0 : rdata_q;

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] core_gnt_q;
    logic [31:0] dbg_gnt_q;
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            core_gnt_q <= '0;
            dbg_gnt_q  <= '0;
            stall_q    <= '0;
        end else begin
            if (grant == GNT_CORE) core_gnt_q <= core_gnt_q + 32'd1;
            if (grant == GNT_DBG)  dbg_gnt_q  <= dbg_gnt_q + 32'd1;
            if (core_stall)        stall_q    <= stall_q + 32'd1;
        end
    end

    assign stat_core_gnt = core_gnt_q;
    assign stat_dbg_gnt  = dbg_gnt_q;
    assign stat_stall    = stall_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a word-addressed behavioural datamemory.
module tb_dmem_arbiter;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    logic [31:0] mem [0:127];

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stat_core_gnt;
    logic [31:0] stat_dbg_gnt;
    logic [31:0] stat_stall;
`endif

    dmem_arbiter_if #(.DATA_W(32), .DM_ADDRESS(9)) bus ();

    dmem_arbiter #(
        .DATA_W     (32),
        .DM_ADDRESS (9),
        .MAX_WAIT   (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
`ifdef DMEM_ARB_STATS_EN
        .stat_core_gnt (stat_core_gnt),
        .stat_dbg_gnt  (stat_dbg_gnt),
        .stat_stall    (stat_stall),
`endif
        .bus           (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_rdata = mem[bus.mem_addr[8:2]];

    always @(posedge clk) begin
        if (bus.mem_wr) mem[bus.mem_addr[8:2]] <= bus.mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        mem[0]  = 32'h1234_5678;
        mem[16] = 32'hDEAD_BEEF;

        reset          = 1'b1;
        bus.core_rd    = 1'b0;
        bus.core_wr    = 1'b0;
        bus.core_addr  = 9'h0;
        bus.core_wdata = 32'h0;
        bus.core_f3    = 3'b010;
        bus.dbg_valid  = 1'b0;
        bus.dbg_we     = 1'b0;
        bus.dbg_addr   = 9'h0;
        bus.dbg_wdata  = 32'h0;
        tick();
        tick();

        // Reset: requests present but nothing reaches memory.
        bus.core_rd   = 1'b1;
        bus.dbg_valid = 1'b1;
        bus.dbg_addr  = 9'h040;
        settle();
        chk1("rst_mem_rd", bus.mem_rd, 1'b0);
        chk1("rst_mem_wr", bus.mem_wr, 1'b0);
        chk1("rst_ready", bus.dbg_ready, 1'b0);
        chk1("rst_stall", bus.core_stall, 1'b0);
        chk1("rst_rvalid", bus.dbg_rvalid, 1'b0);
        chk("rst_rdata", bus.dbg_rdata, 32'h0);
        bus.core_rd   = 1'b0;
        bus.dbg_valid = 1'b0;
        reset         = 1'b0;
        tick();

        // Idle: no grant.
        settle();
        chk1("idle_mem_rd", bus.mem_rd, 1'b0);
        chk1("idle_mem_wr", bus.mem_wr, 1'b0);
        chk("idle_core_rdata", bus.core_rdata, 32'h0);
        tick();

        // Scenario 1: dbg read with core idle.
        bus.dbg_valid = 1'b1;
        bus.dbg_we    = 1'b0;
        bus.dbg_addr  = 9'h040;
        settle();
        chk1("s1_ready", bus.dbg_ready, 1'b1);
        chk1("s1_mem_rd", bus.mem_rd, 1'b1);
        chk("s1_mem_addr", {23'h0, bus.mem_addr}, 32'h40);
        chk("s1_mem_f3", {29'h0, bus.mem_f3}, 32'h2);
        chk1("s1_stall", bus.core_stall, 1'b0);
        chk1("s1_rvalid_early", bus.dbg_rvalid, 1'b0);
        tick();
        bus.dbg_valid = 1'b0;
        settle();
        chk1("s1_rvalid", bus.dbg_rvalid, 1'b1);
        chk("s1_rdata", bus.dbg_rdata, 32'hDEAD_BEEF);
        tick();
        settle();
        chk1("s1_rvalid_pulse", bus.dbg_rvalid, 1'b0);
        tick();

        // Scenario 2: core lw every cycle, dbg forced through on the 5th cycle.
        bus.core_rd   = 1'b1;
        bus.core_addr = 9'h000;
        bus.dbg_valid = 1'b1;
        bus.dbg_addr  = 9'h040;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk1("s2_refused_ready", bus.dbg_ready, 1'b0);
            chk1("s2_refused_stall", bus.core_stall, 1'b0);
            chk("s2_core_rdata", bus.core_rdata, 32'h1234_5678);
            tick();
        end
        settle();
        chk1("s2_forced_ready", bus.dbg_ready, 1'b1);
        chk1("s2_forced_stall", bus.core_stall, 1'b1);
        chk("s2_forced_core_rdata", bus.core_rdata, 32'h0);
        chk("s2_forced_addr", {23'h0, bus.mem_addr}, 32'h40);
        tick();
        bus.dbg_valid = 1'b0;
        settle();
        chk1("s2_after_ready", bus.dbg_ready, 1'b0);
        chk1("s2_after_stall", bus.core_stall, 1'b0);
        chk("s2_after_core_rdata", bus.core_rdata, 32'h1234_5678);
        chk1("s2_rvalid", bus.dbg_rvalid, 1'b1);
        chk("s2_rdata", bus.dbg_rdata, 32'hDEAD_BEEF);
        bus.core_rd = 1'b0;
        tick();

        // Scenario 3: same-address core sw and dbg write; dbg lands last.
        bus.core_wr    = 1'b1;
        bus.core_addr  = 9'h010;
        bus.core_wdata = 32'h11;
        bus.dbg_valid  = 1'b1;
        bus.dbg_we     = 1'b1;
        bus.dbg_addr   = 9'h010;
        bus.dbg_wdata  = 32'h22;
        settle();
        chk1("s3_core_wr", bus.mem_wr, 1'b1);
        chk("s3_core_wdata", bus.mem_wdata, 32'h11);
        chk1("s3_core_ready", bus.dbg_ready, 1'b0);
        tick();
        bus.core_wr = 1'b0;
        settle();
        chk("s3_core_commit", mem[4], 32'h11);
        chk1("s3_dbg_ready", bus.dbg_ready, 1'b1);
        chk1("s3_dbg_wr", bus.mem_wr, 1'b1);
        chk("s3_dbg_wdata", bus.mem_wdata, 32'h22);
        chk1("s3_dbg_stall", bus.core_stall, 1'b0);
        tick();
        bus.dbg_valid = 1'b0;
        bus.dbg_we    = 1'b0;
        bus.core_rd   = 1'b1;
        settle();
        chk("s3_final_word", bus.core_rdata, 32'h22);
        chk1("s3_no_rvalid", bus.dbg_rvalid, 1'b0);
        bus.core_rd = 1'b0;
        tick();

        // Scenario 4: reset right after an accepted dbg read drops the response.
        bus.dbg_valid = 1'b1;
        bus.dbg_addr  = 9'h040;
        settle();
        chk1("s4_ready", bus.dbg_ready, 1'b1);
        tick();
        reset         = 1'b1;
        bus.core_rd   = 1'b1;
        bus.core_addr = 9'h000;
        settle();
        chk1("s4_rvalid", bus.dbg_rvalid, 1'b0);
        chk("s4_rdata", bus.dbg_rdata, 32'h0);
        chk1("s4_mem_rd", bus.mem_rd, 1'b0);
        chk1("s4_mem_wr", bus.mem_wr, 1'b0);
        chk1("s4_ready_rst", bus.dbg_ready, 1'b0);
        chk1("s4_stall_rst", bus.core_stall, 1'b0);
        tick();
        settle();
        chk1("s4_rvalid2", bus.dbg_rvalid, 1'b0);
        chk("s4_rdata2", bus.dbg_rdata, 32'h0);
        reset = 1'b0;
        // Counter restarts at zero after reset: four refusals, then forced.
        for (int i = 0; i < 4; i++) begin
            settle();
            chk1("s4_post_refused", bus.dbg_ready, 1'b0);
            tick();
        end
        settle();
        chk1("s4_post_forced", bus.dbg_ready, 1'b1);
        chk1("s4_post_stall", bus.core_stall, 1'b1);
        tick();
        bus.dbg_valid = 1'b0;
        settle();
        chk("s4_post_rdata", bus.dbg_rdata, 32'hDEAD_BEEF);
        tick();

        // Scenario 5: dbg_valid drop clears the starvation count.
        bus.dbg_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk1("s5_first_refused", bus.dbg_ready, 1'b0);
            tick();
        end
        bus.dbg_valid = 1'b0;
        settle();
        chk1("s5_gap_ready", bus.dbg_ready, 1'b0);
        tick();
        bus.dbg_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk1("s5_refused", bus.dbg_ready, 1'b0);
            chk1("s5_refused_stall", bus.core_stall, 1'b0);
            tick();
        end
        settle();
        chk1("s5_forced", bus.dbg_ready, 1'b1);
        chk1("s5_forced_stall", bus.core_stall, 1'b1);
        tick();
        bus.dbg_valid = 1'b0;
        bus.core_rd   = 1'b0;
        tick();

`ifdef DMEM_ARB_STATS_EN
        // Scenario 6: ten cycles of scenario 2 from reset.
        reset = 1'b1;
        tick();
        reset         = 1'b0;
        bus.core_rd   = 1'b1;
        bus.dbg_valid = 1'b1;
        repeat (10) tick();
        chk("s6_core_gnt", stat_core_gnt, 32'd8);
        chk("s6_dbg_gnt", stat_dbg_gnt, 32'd2);
        chk("s6_stall", stat_stall, 32'd2);
        bus.core_rd   = 1'b0;
        bus.dbg_valid = 1'b0;
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
